// File: rtl/tile_seq_loader.sv
// Tile sequence loader: packs one tile's reference and query base streams into
// BLOCK_WIDTH-base BRAM words, appends bounding pad words, then pulses done.

module tile_seq_loader_lane #(
    parameter int          TILE_SIZE       = 512,
    parameter int          BLOCK_WIDTH     = 8,
    parameter logic [3:0]  PAD             = 4'hF,
    parameter int          LOG_TILE_SIZE   = $clog2(TILE_SIZE),
    parameter int          LOG_BLOCK_WIDTH = $clog2(BLOCK_WIDTH),
    parameter int          AW              = LOG_TILE_SIZE - LOG_BLOCK_WIDTH,
    parameter int          DW              = 4 * BLOCK_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   run,
    input  logic                   pad_go,
    input  logic [LOG_TILE_SIZE:0] len,
    input  logic                   valid,
    input  logic [3:0]             base,
    output logic                   ready,
    output logic                   wen,
    output logic [AW-1:0]          addr,
    output logic [DW-1:0]          din,
    output logic                   data_done,
    output logic                   pad_pend
);
    localparam logic [LOG_TILE_SIZE:0] TILE_LEN = (LOG_TILE_SIZE+1)'(TILE_SIZE);
    localparam logic [DW-1:0]          PAD_WORD = {BLOCK_WIDTH{PAD}};

    logic [LOG_TILE_SIZE:0]   count;
    logic [LOG_TILE_SIZE:0]   len_q;
    logic [LOG_TILE_SIZE:0]   len_sat;
    logic [LOG_TILE_SIZE:0]   count_next;
    logic [DW-1:0]            word;
    logic [DW-1:0]            word_next;
    logic [LOG_BLOCK_WIDTH-1:0] idx;
    logic                     accept;
    logic                     flush;

    assign len_sat    = (len > TILE_LEN) ? TILE_LEN : len;
    assign ready      = run && (count < len_q);
    assign accept     = valid && ready;
    assign idx        = count[LOG_BLOCK_WIDTH-1:0];
    assign count_next = count + {{LOG_TILE_SIZE{1'b0}}, accept};
    assign data_done  = (count_next == len_q);
    assign flush      = accept && ((idx == LOG_BLOCK_WIDTH'(BLOCK_WIDTH-1)) || (count_next == len_q));

    always_comb begin
        word_next = word;
        if (accept) begin
            word_next[{idx, 2'b00} +: 4] = base;
        end
    end

    // The packer is refilled with pad after every write, so a partial final
    // word already carries its terminating pad nibbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            len_q    <= '0;
            word     <= '0;
            pad_pend <= 1'b0;
            wen      <= 1'b0;
            addr     <= '0;
            din      <= '0;
        end else if (clear) begin
            count    <= '0;
            len_q    <= len_sat;
            word     <= PAD_WORD;
            pad_pend <= (len_sat[LOG_BLOCK_WIDTH-1:0] == '0) && (len_sat < TILE_LEN);
            wen      <= 1'b0;
        end else begin
            wen   <= 1'b0;
            count <= count_next;
            if (flush) begin
                wen  <= 1'b1;
                addr <= count[LOG_TILE_SIZE-1:LOG_BLOCK_WIDTH];
                din  <= word_next;
                word <= PAD_WORD;
            end else begin
                word <= word_next;
            end
            if (pad_go && pad_pend) begin
                wen      <= 1'b1;
                addr     <= len_q[LOG_TILE_SIZE-1:LOG_BLOCK_WIDTH];
                din      <= PAD_WORD;
                pad_pend <= 1'b0;
            end
        end
    end
endmodule

module tile_seq_loader #(
    parameter int         TILE_SIZE       = 512,
    parameter int         LOG_TILE_SIZE   = $clog2(TILE_SIZE),
    parameter int         BLOCK_WIDTH     = 8,
    parameter int         LOG_BLOCK_WIDTH = $clog2(BLOCK_WIDTH),
    parameter logic [3:0] REF_PAD         = 4'hF,
    parameter logic [3:0] QRY_PAD         = 4'hE
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [LOG_TILE_SIZE:0]                   ref_len,
    input  logic [LOG_TILE_SIZE:0]                   qry_len,
    input  logic                                     ref_valid,
    output logic                                     ref_ready,
    input  logic [3:0]                               ref_base,
    input  logic                                     qry_valid,
    output logic                                     qry_ready,
    input  logic [3:0]                               qry_base,
    output logic                                     rwr_wen,
    output logic [LOG_TILE_SIZE-LOG_BLOCK_WIDTH-1:0] rwr_addr,
    output logic [4*BLOCK_WIDTH-1:0]                 rwr_din,
    output logic                                     qwr_wen,
    output logic [LOG_TILE_SIZE-LOG_BLOCK_WIDTH-1:0] qwr_addr,
    output logic [4*BLOCK_WIDTH-1:0]                 qwr_din,
    output logic                                     load,
    output logic                                     busy,
    output logic                                     done,
    output logic [1:0]                               state_dbg
);
    // Handshake: a base moves when valid && ready at a rising clk edge; ready
    // never depends on valid, and valid may be raised or dropped freely.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] PAD  = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       clear;
    logic       r_done, q_done, r_pend, q_pend;

    assign clear     = (state == IDLE) && start;
    assign load      = (state == LOAD) || (state == PAD);
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign state_dbg = state;

    // PAD lingers until pending pad writes have been issued, so FIN lands in
    // the cycle right after the last registered write becomes visible.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: if (r_done && q_done) state_next = PAD;
            PAD:  if (!r_pend && !q_pend) state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    tile_seq_loader_lane #(.TILE_SIZE(TILE_SIZE), .BLOCK_WIDTH(BLOCK_WIDTH), .PAD(REF_PAD)) u_ref (
        .clk(clk), .rst(rst), .clear(clear), .run(state == LOAD), .pad_go(state == PAD),
        .len(ref_len), .valid(ref_valid), .base(ref_base), .ready(ref_ready),
        .wen(rwr_wen), .addr(rwr_addr), .din(rwr_din), .data_done(r_done), .pad_pend(r_pend)
    );

    tile_seq_loader_lane #(.TILE_SIZE(TILE_SIZE), .BLOCK_WIDTH(BLOCK_WIDTH), .PAD(QRY_PAD)) u_qry (
        .clk(clk), .rst(rst), .clear(clear), .run(state == LOAD), .pad_go(state == PAD),
        .len(qry_len), .valid(qry_valid), .base(qry_base), .ready(qry_ready),
        .wen(qwr_wen), .addr(qwr_addr), .din(qwr_din), .data_done(q_done), .pad_pend(q_pend)
    );
endmodule

// File: tb/tb_tile_seq_loader.sv
// Self-checking bench for tile_seq_loader: vector table, reset/busy-start
// corner sequences and randomized tiles checked against a word-level model.

module tb_tile_seq_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  ref_len, qry_len;
    logic        ref_valid, qry_valid;
    logic        ref_ready, qry_ready;
    logic [3:0]  ref_base, qry_base;
    logic        rwr_wen, qwr_wen;
    logic [5:0]  rwr_addr, qwr_addr;
    logic [31:0] rwr_din, qwr_din;
    logic        load, busy, done;
    logic [1:0]  state_dbg;

    tile_seq_loader dut (
        .clk(clk), .rst(rst), .start(start), .ref_len(ref_len), .qry_len(qry_len),
        .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_base(ref_base),
        .qry_valid(qry_valid), .qry_ready(qry_ready), .qry_base(qry_base),
        .rwr_wen(rwr_wen), .rwr_addr(rwr_addr), .rwr_din(rwr_din),
        .qwr_wen(qwr_wen), .qwr_addr(qwr_addr), .qwr_din(qwr_din),
        .load(load), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          rlen, qlen;
        int          roff, qoff;      // base pattern (i+off)%4, or random when < 0
        int          rgap, qgap;      // percent chance of valid=0 per cycle
        int          qdel;            // cycles before the query lane starts
        bit          spulse;          // pulse start while busy and in FIN
        bit          chk;             // compare first written words
        logic [31:0] exp_r0, exp_q0;
        int          exp_rw, exp_qw;  // write counts per lane
        int          exp_ra, exp_qa;  // last written address per lane
    } vec_t;

    vec_t        vecs[$];
    logic [37:0] exp_r[$];
    logic [37:0] exp_q[$];
    logic [3:0]  rbases[512];
    logic [3:0]  qbases[512];

    int          checks = 0;
    int          failures = 0;
    int          r_cnt = 0, q_cnt = 0;
    logic [5:0]  r_last, q_last;
    logic [31:0] r_first, q_first;
    bit          r_seen, q_seen;
    time         last_wen_t = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_lane(input int lane, input int len);
        int          l;
        logic [3:0]  pad;
        logic [31:0] w;
        l   = (len > 512) ? 512 : len;
        pad = lane ? 4'hE : 4'hF;
        for (int wi = 0; wi < (l + 7) / 8; wi++) begin
            for (int j = 0; j < 8; j++) begin
                int idx;
                idx = wi * 8 + j;
                w[j*4 +: 4] = (idx < l) ? (lane ? qbases[idx] : rbases[idx]) : pad;
            end
            if (lane) exp_q.push_back({6'(wi), w});
            else      exp_r.push_back({6'(wi), w});
        end
        if ((l % 8 == 0) && (l < 512)) begin
            if (lane) exp_q.push_back({6'(l / 8), {8{pad}}});
            else      exp_r.push_back({6'(l / 8), {8{pad}}});
        end
    endtask

    function automatic int writes_for(input int len);
        int l;
        l = (len > 512) ? 512 : len;
        return (l + 7) / 8 + (((l % 8 == 0) && (l < 512)) ? 1 : 0);
    endfunction

    task automatic mon_step();
        if (rwr_wen) begin
            r_cnt++;
            r_last = rwr_addr;
            last_wen_t = $time;
            if (!r_seen) begin r_first = rwr_din; r_seen = 1'b1; end
            check("load_during_rwr", 80'(load), 80'(1));
            if (exp_r.size() == 0) begin
                checks++; failures++;
                $display("FAIL ref_unexpected_write: addr %0d din %h, expected no write", rwr_addr, rwr_din);
            end else check("ref_word", 80'({rwr_addr, rwr_din}), 80'(exp_r.pop_front()));
        end
        if (qwr_wen) begin
            q_cnt++;
            q_last = qwr_addr;
            last_wen_t = $time;
            if (!q_seen) begin q_first = qwr_din; q_seen = 1'b1; end
            check("load_during_qwr", 80'(load), 80'(1));
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL qry_unexpected_write: addr %0d din %h, expected no write", qwr_addr, qwr_din);
            end else check("qry_word", 80'({qwr_addr, qwr_din}), 80'(exp_q.pop_front()));
        end
    endtask

    task automatic drive_lane(input int lane, input int n, input int gap, input int delay, output bit to);
        to = 1'b0;
        repeat (delay) @(posedge clk);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int tries;
            acc = 1'b0;
            tries = 0;
            while (!acc) begin
                bit v;
                @(negedge clk);
                tries++;
                if (tries > 4000) begin
                    to = 1'b1;
                    if (lane) qry_valid = 1'b0; else ref_valid = 1'b0;
                    return;
                end
                v = ($urandom_range(0, 99) >= gap);
                if (lane) begin qry_valid = v; qry_base = qbases[i]; acc = v && qry_ready; end
                else      begin ref_valid = v; ref_base = rbases[i]; acc = v && ref_ready; end
            end
        end
        @(negedge clk);
        if (lane) qry_valid = 1'b0; else ref_valid = 1'b0;
    endtask

    task automatic fill_bases(input int roff, input int qoff);
        for (int i = 0; i < 512; i++) begin
            rbases[i] = (roff < 0) ? 4'($urandom_range(0, 15)) : 4'((i + roff) % 4);
            qbases[i] = (qoff < 0) ? 4'($urandom_range(0, 15)) : 4'((i + qoff) % 4);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int  r0, q0, rl, ql;
        bit  to_r, to_q, seen;
        fill_bases(v.roff, v.qoff);
        model_lane(0, v.rlen);
        model_lane(1, v.qlen);
        r0 = r_cnt; q0 = q_cnt;
        r_seen = 1'b0; q_seen = 1'b0;
        rl = (v.rlen > 512) ? 512 : v.rlen;
        ql = (v.qlen > 512) ? 512 : v.qlen;
        @(negedge clk);
        start = 1'b1; ref_len = 10'(v.rlen); qry_len = 10'(v.qlen);
        @(negedge clk);
        start = 1'b0;
        check("start_load_busy", 80'({load, busy}), 80'(2'b11));
        if (v.spulse) begin
            start = 1'b1; ref_len = 10'd3; qry_len = 10'd3;
            @(negedge clk);
            start = 1'b0;
        end
        fork
            drive_lane(0, rl, v.rgap, 0, to_r);
            drive_lane(1, ql, v.qgap, v.qdel, to_q);
        join
        check("ref_drive_timeout", 80'(to_r), 80'(0));
        check("qry_drive_timeout", 80'(to_q), 80'(0));
        check("ready_low_after_data", 80'({ref_ready, qry_ready}), 80'(0));
        seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("done_seen", 80'(seen), 80'(1));
        check("load_low_at_done", 80'(load), 80'(0));
        check("done_after_last_wen", 80'($time - last_wen_t), 80'(10));
        if (v.spulse) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("idle_after_fin", 80'({busy, done}), 80'(0));
        check("ref_write_count", 80'(r_cnt - r0), 80'(v.exp_rw));
        check("qry_write_count", 80'(q_cnt - q0), 80'(v.exp_qw));
        check("ref_last_addr", 80'(r_last), 80'(v.exp_ra));
        check("qry_last_addr", 80'(q_last), 80'(v.exp_qa));
        if (v.chk) begin
            check("ref_first_din", 80'(r_first), 80'(v.exp_r0));
            check("qry_first_din", 80'(q_first), 80'(v.exp_q0));
        end
        check("exp_queues_empty", 80'(exp_r.size() + exp_q.size()), 80'(0));
        exp_r.delete();
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; ref_len = '0; qry_len = '0;
        ref_valid = 1'b0; qry_valid = 1'b0; ref_base = '0; qry_base = '0;
        fork
            forever begin @(negedge clk); mon_step(); end
        join_none

        //           rlen qlen roff qoff rg qg qd sp chk exp_r0        exp_q0        rw qw ra qa
        vecs.push_back('{16,  16,  0,  0,  0, 0, 0, 0, 1, 32'h32103210, 32'h32103210, 3, 3, 2, 2});
        vecs.push_back('{5,   3,   1,  0,  0, 0, 0, 0, 1, 32'hFFF10321, 32'hEEEEE210, 1, 1, 0, 0});
        vecs.push_back('{0,   8,   0,  0,  0, 0, 0, 0, 1, 32'hFFFFFFFF, 32'h32103210, 1, 2, 0, 1});
        vecs.push_back('{512, 8,  -1, -1,  0, 0, 0, 0, 0, 32'h0,        32'h0,        64, 2, 63, 1});
        vecs.push_back('{600, 0,  -1, -1,  0, 0, 0, 1, 0, 32'h0,        32'h0,        64, 1, 63, 0});
        vecs.push_back('{16,  16,  0,  0, 30, 30, 40, 0, 1, 32'h32103210, 32'h32103210, 3, 3, 2, 2});
        vecs.push_back('{9,   24, -1, -1, 20, 10, 0, 1, 0, 32'h0,        32'h0,        2, 4, 1, 3});
        vecs.push_back('{7,   504, -1, -1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 64, 0, 63});

        repeat (3) @(negedge clk);
        check("reset_outputs", 80'({rwr_wen, qwr_wen, rwr_addr, qwr_addr, rwr_din, qwr_din,
                                    load, busy, done, ref_ready, qry_ready}), 80'(0));
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[k]) run_vec(vecs[k]);

        // Reset in the middle of a load, after one word has been written.
        fill_bases(0, 0);
        model_lane(0, 64);
        model_lane(1, 64);
        start = 1'b1; ref_len = 10'd64; qry_len = 10'd64;
        @(negedge clk);
        start = 1'b0;
        ref_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            ref_base = rbases[i];
            @(negedge clk);
        end
        ref_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("async_reset_outputs", 80'({rwr_wen, qwr_wen, rwr_addr, qwr_addr, rwr_din, qwr_din,
                                             load, busy, done, ref_ready, qry_ready}), 80'(0));
        exp_r.delete();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_vec(vecs[0]);

        for (int n = 0; n < 6; n++) begin
            vec_t v;
            v.rlen = $urandom_range(0, 600);
            v.qlen = $urandom_range(0, 600);
            v.roff = -1; v.qoff = -1;
            v.rgap = $urandom_range(0, 50); v.qgap = $urandom_range(0, 50);
            v.qdel = $urandom_range(0, 40);
            v.spulse = 1'($urandom_range(0, 1));
            v.chk = 1'b0; v.exp_r0 = '0; v.exp_q0 = '0;
            v.exp_rw = writes_for(v.rlen);
            v.exp_qw = writes_for(v.qlen);
            v.exp_ra = v.exp_rw - 1;
            v.exp_qa = v.exp_qw - 1;
            run_vec(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
